// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the in-order pipeline
//   write-back path and a long-latency external unit. The pipeline always
//   wins. External results wait in a small FIFO and retire in the idle
//   write-back slots. If the FIFO stays blocked for too long, a one-slot
//   pipeline stall is requested so that buffered results always retire.
//   All regfile-side outputs are registered.
//
//   Optional build macro: WB_ARB_BYPASS_EN
//     If it is defined, an external result that arrives while the FIFO is
//     empty and the pipeline is idle goes straight to the outputs, so it
//     retires with 1-cycle latency.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_NORM  | normal arbitration; blocked cycles counted toward starvation
//   S_STALL | stall_pipe asserted until an external entry is granted
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_we,
  input  logic [ADDR_W-1:0]            pipe_addr,
  input  logic [DATA_W-1:0]            pipe_data,
  input  logic                         ext_valid,
  output logic                         ext_ready,
  input  logic [ADDR_W-1:0]            ext_addr,
  input  logic [DATA_W-1:0]            ext_data,
  output logic                         stall_pipe,
  output logic [ADDR_W-1:0]            reg_write_addr,
  output logic [DATA_W-1:0]            reg_write_data,
  output logic                         reg_write_enable,
  output logic                         wb_src,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = $clog2(STARVE_LIMIT+1);

  localparam logic [0:0] S_NORM  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [0:0]        state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              src_q, src_d;

  logic              empty, full;
  logic              pipe_req, grant_ext, bypass, push, pop, blocked;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pipe_req  = pipe_we && (pipe_addr != '0);
  assign grant_ext = !pipe_req && !empty;
  assign blocked   = pipe_req && !empty;
  assign head_addr = mem_addr[rd_ptr_q];
  assign head_data = mem_data[rd_ptr_q];

`ifdef WB_ARB_BYPASS_EN
  assign bypass = empty && !pipe_req && ext_valid;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on the registered count, so a pop in the same
  // cycle never lets a full FIFO accept a new entry.
  assign ext_ready = !full;
  assign push      = ext_valid && ext_ready && !bypass;
  assign pop       = grant_ext;

  assign stall_pipe       = (state_q == S_STALL);
  assign reg_write_addr   = addr_q;
  assign reg_write_data   = data_q;
  assign reg_write_enable = en_q;
  assign wb_src           = src_q;
  assign fifo_count       = count_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Grant selection for the registered write port
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    en_d   = 1'b0;
    if (pipe_req) begin
      addr_d = pipe_addr;
      data_d = pipe_data;
      src_d  = 1'b0;
      en_d   = 1'b1;
    end else if (grant_ext) begin
      // An x0 entry is consumed but never written.
      addr_d = head_addr;
      data_d = head_data;
      src_d  = 1'b1;
      en_d   = (head_addr != '0);
    end else if (bypass) begin
      addr_d = ext_addr;
      data_d = ext_data;
      src_d  = 1'b1;
      en_d   = (ext_addr != '0);
    end
  end

  // Starvation tracking: count blocked cycles, stall at the limit
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (grant_ext || bypass) begin
      state_d  = S_NORM;
      starve_d = '0;
    end else if (blocked && (state_q == S_NORM)) begin
      if (starve_q == STV_W'(STARVE_LIMIT-1)) state_d = S_STALL;
      else                                     starve_d = starve_q + STV_W'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= ext_addr;
      mem_data[wr_ptr_q] <= ext_data;
    end
  end

  // State, pointer and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= S_NORM;
      addr_q   <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
      src_q    <= src_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic.
// Every step is also checked against a queue-based behavioural model.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int CNT_W        = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              ext_valid;
  logic              ext_ready;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic              stall_pipe;
  logic [ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0] reg_write_data;
  logic              reg_write_enable;
  logic              wb_src;
  logic [CNT_W-1:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_addr(ext_addr), .ext_data(ext_data),
    .stall_pipe(stall_pipe),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .wb_src(wb_src),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of pending results, a blocked-cycle tally
  // and a stall flag, updated once per clock from the rules of the block.
  logic [ADDR_W+DATA_W-1:0] m_q[$];
  logic [ADDR_W-1:0]        m_addr;
  logic [DATA_W-1:0]        m_data;
  bit                       m_en, m_src, m_stall;
  int                       m_blk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit preq, byp, push, blocked;
    logic [ADDR_W+DATA_W-1:0] head;
    if (!reset) begin
      m_q.delete();
      m_addr = '0; m_data = '0; m_en = 0; m_src = 0; m_stall = 0; m_blk = 0;
      return;
    end
    preq = pipe_we && (pipe_addr != 0);
    byp  = 0;
`ifdef WB_ARB_BYPASS_EN
    byp = (m_q.size() == 0) && !preq && ext_valid;
`endif
    push    = ext_valid && (m_q.size() < DEPTH) && !byp;
    blocked = preq && (m_q.size() != 0);
    if (preq) begin
      m_en = 1; m_src = 0; m_addr = pipe_addr; m_data = pipe_data;
    end else if (m_q.size() != 0) begin
      head   = m_q.pop_front();
      m_addr = head[ADDR_W+DATA_W-1:DATA_W];
      m_data = head[DATA_W-1:0];
      m_en   = (m_addr != 0);
      m_src  = 1;
      m_blk  = 0;
      m_stall = 0;
    end else if (byp) begin
      m_addr = ext_addr; m_data = ext_data; m_en = (ext_addr != 0); m_src = 1;
      m_blk = 0; m_stall = 0;
    end else begin
      m_en = 0;
    end
    if (blocked && !m_stall) begin
      m_blk++;
      if (m_blk >= STARVE_LIMIT) m_stall = 1;
    end
    if (push) m_q.push_back({ext_addr, ext_data});
  endtask

  // One clock: check ready, advance the model, take the edge, check outputs.
  task automatic step();
    if (reset) chk("ext_ready", 64'(ext_ready), 64'(m_q.size() < DEPTH));
    model_update();
    @(posedge clk);
    #1;
    chk("we",    64'(reg_write_enable), 64'(m_en));
    chk("src",   64'(wb_src),           64'(m_src));
    chk("addr",  64'(reg_write_addr),   64'(m_addr));
    chk("data",  64'(reg_write_data),   64'(m_data));
    chk("stall", 64'(stall_pipe),       64'(m_stall));
    chk("count", 64'(fifo_count),       64'(m_q.size()));
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_addr = '0; pipe_data = '0;
    ext_valid = 0; ext_addr = '0; ext_data = '0;
  endtask

  task automatic drive(input bit pw, input int pa, input logic [31:0] pd,
                       input bit ev, input int ea, input logic [31:0] ed);
    pipe_we = pw; pipe_addr = ADDR_W'(pa); pipe_data = pd;
    ext_valid = ev; ext_addr = ADDR_W'(ea); ext_data = ed;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    m_q.delete(); m_en = 0; m_src = 0; m_stall = 0; m_blk = 0;
    m_addr = '0; m_data = '0;
    #1;

    // Reset with random inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), $urandom_range(0, 31), $urandom,
            1'($urandom), $urandom_range(0, 31), $urandom);
      step();
    end
    chk("rst_we",    64'(reg_write_enable), 64'(0));
    chk("rst_addr",  64'(reg_write_addr),   64'(0));
    chk("rst_data",  64'(reg_write_data),   64'(0));
    chk("rst_stall", 64'(stall_pipe),       64'(0));
    chk("rst_count", 64'(fifo_count),       64'(0));
    reset = 1;
    idle_inputs();
    step();
    step();
    chk("idle_we", 64'(reg_write_enable), 64'(0));

    // Pipeline priority over a simultaneous external push
    drive(1, 5, 32'hDEADBEEF, 1, 7, 32'h1234);
    step();
    chk("prio_pipe_addr", 64'(reg_write_addr), 64'(5));
    chk("prio_pipe_src",  64'(wb_src),         64'(0));
    chk("prio_pipe_data", 64'(reg_write_data), 64'(32'hDEADBEEF));
    idle_inputs();
    step();
    chk("prio_ext_addr", 64'(reg_write_addr),   64'(7));
    chk("prio_ext_data", 64'(reg_write_data),   64'(32'h1234));
    chk("prio_ext_src",  64'(wb_src),           64'(1));
    chk("prio_ext_we",   64'(reg_write_enable), 64'(1));

    // x0 handling on both sides
    drive(1, 1, 32'h11, 1, 3, 32'h55);
    step();
    drive(1, 0, 32'h99, 0, 0, 0);
    step();
    chk("x0pipe_addr", 64'(reg_write_addr),   64'(3));
    chk("x0pipe_data", 64'(reg_write_data),   64'(32'h55));
    chk("x0pipe_we",   64'(reg_write_enable), 64'(1));
    drive(1, 2, 32'h22, 1, 0, 32'h77);
    step();
    chk("x0ext_cnt1", 64'(fifo_count), 64'(1));
    idle_inputs();
    step();
    chk("x0ext_we",   64'(reg_write_enable), 64'(0));
    chk("x0ext_src",  64'(wb_src),           64'(1));
    chk("x0ext_cnt0", 64'(fifo_count),       64'(0));

    // Full FIFO with the pipeline busy
    for (int k = 0; k < 4; k++) begin
      drive(1, 10 + k, 32'(k), 1, 20 + k, 32'(100 + k));
      step();
    end
    chk("full_cnt",   64'(fifo_count), 64'(4));
    chk("full_ready", 64'(ext_ready),  64'(0));
    for (int k = 0; k < 2; k++) begin
      drive(1, 14 + k, 32'(4 + k), 1, 24, 32'(104));
      step();
      chk("full_hold", 64'(fifo_count), 64'(4));
    end
    drive(0, 0, 0, 1, 24, 32'(104));
    step();
    chk("full_pop_addr", 64'(reg_write_addr), 64'(20));
    chk("full_nopush",   64'(fifo_count),     64'(3));
    step();
    chk("full_pp_addr", 64'(reg_write_addr), 64'(21));
    chk("full_pp_cnt",  64'(fifo_count),     64'(3));
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_order", 64'(reg_write_addr), 64'(22 + k));
    end
    chk("full_empty", 64'(fifo_count), 64'(0));

    // Starvation: one entry buffered, pipeline writing every cycle
    drive(1, 1, 32'h1, 1, 6, 32'h66);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 2, 32'(i), 0, 0, 0);
      step();
      chk("stv_rise", 64'(stall_pipe), 64'(i == 8));
    end
    step();
    chk("stv_pipe_wins", 64'(wb_src),     64'(0));
    chk("stv_held",      64'(stall_pipe), 64'(1));
    idle_inputs();
    step();
    chk("stv_drain_addr", 64'(reg_write_addr),   64'(6));
    chk("stv_drain_we",   64'(reg_write_enable), 64'(1));
    chk("stv_fall",       64'(stall_pipe),       64'(0));
    // A cleared counter needs the full limit again before stalling
    drive(1, 1, 32'h1, 1, 8, 32'h88);
    step();
    for (int i = 1; i <= 7; i++) begin
      drive(1, 2, 32'(i), 0, 0, 0);
      step();
      chk("stv_recount", 64'(stall_pipe), 64'(0));
    end
    idle_inputs();
    step();

    // Reset while stalled with entries buffered
    drive(1, 1, 32'h1, 1, 9, 32'h91);
    step();
    drive(1, 2, 32'h2, 1, 10, 32'h92);
    step();
    drive(1, 3, 32'h3, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_stall", 64'(stall_pipe), 64'(1));
    reset = 0;
    step();
    reset = 1;
    chk("mid_rst_cnt",   64'(fifo_count), 64'(0));
    chk("mid_rst_stall", 64'(stall_pipe), 64'(0));
    idle_inputs();
    step();
    chk("post_rst_we", 64'(reg_write_enable), 64'(0));

    // Single external result into an empty FIFO with an idle pipeline
    drive(0, 0, 0, 1, 9, 32'hA5);
    step();
`ifdef WB_ARB_BYPASS_EN
    chk("byp_we",   64'(reg_write_enable), 64'(1));
    chk("byp_addr", 64'(reg_write_addr),   64'(9));
    chk("byp_cnt",  64'(fifo_count),       64'(0));
    idle_inputs();
    step();
`else
    chk("nobyp_we",  64'(reg_write_enable), 64'(0));
    chk("nobyp_cnt", 64'(fifo_count),       64'(1));
    idle_inputs();
    step();
    chk("nobyp_late_we",   64'(reg_write_enable), 64'(1));
    chk("nobyp_late_addr", 64'(reg_write_addr),   64'(9));
    chk("nobyp_late_data", 64'(reg_write_data),   64'(32'hA5));
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      pipe_we   = m_stall ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 99) < 70);
      pipe_addr = ADDR_W'($urandom_range(0, 7));
      pipe_data = $urandom;
      ext_valid = 1'($urandom_range(0, 99) < 45);
      ext_addr  = ADDR_W'($urandom_range(0, 7));
      ext_data  = $urandom;
      step();
    end
    reset = 1;
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    chk("final_empty", 64'(fifo_count), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
